// File: rtl/mdu_pkg.sv
// ============================================================================
// Module  : mdu_pkg
// Brief   : MDU control codes, FSM state type and decode helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    function automatic logic is_mdu_start(input logic [3:0] ctrl);
        case (ctrl)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU,
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [3:0] ctrl);
        return (ctrl == MDU_DIV) || (ctrl == MDU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module  : mdu_arith
// Brief   : Combinational 2*WIDTH multiply / MAC / divide result and div-by-zero flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         ctrl,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    logic               w_signed;
    logic [2*WIDTH-1:0] w_a_ext;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_acc;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_divisor;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    always_comb begin
        w_signed = (ctrl == MDU_MULT) || (ctrl == MDU_DIV) ||
                   (ctrl == MDU_MADD) || (ctrl == MDU_MSUB);

        // Extending to 2*WIDTH first makes the truncated product correct for both signednesses
        w_a_ext = w_signed ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
        w_b_ext = w_signed ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
        w_prod  = w_a_ext * w_b_ext;
        w_acc   = {hi, lo};

        // Signed divide via magnitudes; -2^(W-1)/-1 wraps naturally to 0x80..0 rem 0
        w_a_neg     = w_signed && rs_val[WIDTH-1];
        w_b_neg     = w_signed && rt_val[WIDTH-1];
        w_abs_a     = w_a_neg ? -rs_val : rs_val;
        w_abs_b     = w_b_neg ? -rt_val : rt_val;
        div_by_zero = (rt_val == '0);
        w_divisor   = div_by_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_abs_b;
        w_uq        = w_abs_a / w_divisor;
        w_ur        = w_abs_a % w_divisor;
        w_quot      = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
        w_rem       = w_a_neg ? -w_ur : w_ur;

        case (ctrl)
            MDU_MULT, MDU_MULTU: result = w_prod;
            MDU_MADD, MDU_MADDU: result = w_acc + w_prod;
            MDU_MSUB, MDU_MSUBU: result = w_acc - w_prod;
            MDU_DIV,  MDU_DIVU:  result = {w_rem, w_quot};
            default:             result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/e_mdu.sv
// ============================================================================
// Module  : e_mdu
// Brief   : Multi-cycle multiply/divide unit with HI/LO, busy counter and flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module e_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] rdata
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

    mdu_state_t         r_state, w_state_next;
    logic [CNT_W-1:0]   r_count, w_count_next;
    logic [2*WIDTH-1:0] r_pending, w_pending_next;
    logic               r_commit_ok, w_commit_ok_next;
    logic [WIDTH-1:0]   r_hi, w_hi_next;
    logic [WIDTH-1:0]   r_lo, w_lo_next;
    logic [2*WIDTH-1:0] w_result;
    logic               w_div_by_zero;

    mdu_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .ctrl        (ctrl),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .hi          (r_hi),
        .lo          (r_lo),
        .result      (w_result),
        .div_by_zero (w_div_by_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_pending   <= '0;
            r_commit_ok <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_pending   <= w_pending_next;
            r_commit_ok <= w_commit_ok_next;
            r_hi        <= w_hi_next;
            r_lo        <= w_lo_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_pending_next   = r_pending;
        w_commit_ok_next = r_commit_ok;
        w_hi_next        = r_hi;
        w_lo_next        = r_lo;

        case (r_state)
            ST_IDLE: begin
                if (!flush) begin
                    if (start && is_mdu_start(ctrl)) begin
                        w_pending_next   = w_result;
                        w_commit_ok_next = !(is_div(ctrl) && w_div_by_zero);
                        w_count_next     = is_div(ctrl) ? C_DIV_LOAD : C_MULT_LOAD;
                        w_state_next     = ST_RUN;
                    end else if (ctrl == MDU_MTHI) begin
                        w_hi_next = rs_val;
                    end else if (ctrl == MDU_MTLO) begin
                        w_lo_next = rs_val;
                    end
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_count_next     = '0;
                    w_state_next     = ST_IDLE;
                    w_pending_next   = '0;
                    w_commit_ok_next = 1'b0;
                end else begin
                    w_count_next = r_count - C_ONE;
                    if (r_count == C_ONE) begin
                        w_state_next     = ST_IDLE;
                        w_pending_next   = '0;
                        w_commit_ok_next = 1'b0;
                        if (r_commit_ok) begin
                            {w_hi_next, w_lo_next} = r_pending;
                        end
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        case (ctrl)
            MDU_MFHI: rdata = r_hi;
            MDU_MFLO: rdata = r_lo;
            default:  rdata = '0;
        endcase
    end

    assign busy   = (r_state == ST_RUN);
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_e_mdu.sv
// ============================================================================
// Module  : tb_e_mdu
// Brief   : Scoreboard bench for e_mdu: directed ops, monitor checks on busy fall / check strobe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] rdata;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] rd;
        int          len;
        bit          chk_rd;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_req  = 1'b0;

    e_mdu #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .ctrl   (ctrl),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .hi_out (hi_out),
        .lo_out (lo_out),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per busy fall or per check strobe
    logic busy_prev = 1'b0;
    int   run_len   = 0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) run_len++;
        if ((busy_prev && busy !== 1'b1) || chk_req) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got busy=%0b with empty scoreboard, expected none", busy);
            end else begin
                e = q.pop_front();
                cmp({e.name, ".hi"}, hi_out, e.hi);
                cmp({e.name, ".lo"}, lo_out, e.lo);
                if (e.chk_rd) cmp({e.name, ".rdata"}, rdata, e.rd);
                if (e.len >= 0) cmp({e.name, ".busy_len"}, 32'(run_len), 32'(e.len));
            end
            if (!busy) run_len = 0;
        end
        busy_prev = busy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.timeout: got %0d pending items, expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic check(input string name, input logic [3:0] c,
                         input logic [31:0] eh, input logic [31:0] el, input logic [31:0] er);
        q.push_back('{name, eh, el, er, -1, 1'b1});
        ctrl    = c;
        chk_req = 1'b1;
        tick();
        chk_req = 1'b0;
        ctrl    = 4'd0;
        drain(name);
    endtask

    task automatic op(input string name, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                      input int len);
        q.push_back('{name, eh, el, 32'h0, len, 1'b0});
        start  = 1'b1;
        ctrl   = c;
        rs_val = a;
        rt_val = b;
        tick();
        start  = 1'b0;
        ctrl   = 4'd0;
        drain(name);
    endtask

    task automatic mt(input logic [3:0] c, input logic [31:0] v);
        ctrl   = c;
        rs_val = v;
        tick();
        ctrl   = 4'd0;
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        ctrl   = 4'd0;
        rs_val = '0;
        rt_val = '0;
        flush  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("reset_state", 4'd5, 32'h0, 32'h0, 32'h0);

        op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        check("mfhi_after_mult", 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF);
        check("mflo_after_mult", 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFA);
        op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
        op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
        op("divu", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);

        mt(4'd7, 32'h0);
        mt(4'd8, 32'hFFFF_FFFF);
        check("mthi_mtlo", 4'd6, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        op("madd", 4'd9, 32'd1, 32'd1, 32'h1, 32'h0, 5);
        op("msubu", 4'd12, 32'd2, 32'd1, 32'h0, 32'hFFFF_FFFE, 5);
        op("maddu", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 5);
        op("msub", 4'd11, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'h0000_0001, 5);

        mt(4'd7, 32'h11);
        mt(4'd8, 32'h22);
        op("divu_by_zero", 4'd4, 32'd7, 32'd0, 32'h11, 32'h22, 10);

        // Flush in the third busy cycle, with an mthi and a start ignored while busy
        q.push_back('{"flush", 32'h11, 32'h22, 32'h0, 3, 1'b0});
        start  = 1'b1;
        ctrl   = 4'd1;
        rs_val = 32'd5;
        rt_val = 32'd5;
        tick();
        start  = 1'b0;
        ctrl   = 4'd7;
        rs_val = 32'hDEAD;
        tick();
        start  = 1'b1;
        ctrl   = 4'd1;
        rs_val = 32'd9;
        tick();
        start  = 1'b0;
        ctrl   = 4'd0;
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
        drain("flush");
        repeat (8) tick();
        check("after_flush", 4'd5, 32'h11, 32'h22, 32'h11);

        // Reset asserted mid-divide
        start  = 1'b1;
        ctrl   = 4'd3;
        rs_val = 32'd100;
        rt_val = 32'd3;
        tick();
        start  = 1'b0;
        ctrl   = 4'd0;
        repeat (3) tick();
        q.push_back('{"reset_mid_div", 32'h0, 32'h0, 32'h0, -1, 1'b0});
        #1 reset = 1'b1;
        tick();
        reset = 1'b0;
        drain("reset_mid_div");
        repeat (12) tick();
        check("after_reset_mfhi", 4'd5, 32'h0, 32'h0, 32'h0);
        check("after_reset_mflo", 4'd6, 32'h0, 32'h0, 32'h0);

        repeat (3) tick();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover: got %0d items, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
